zxuno_port_bridge: RTL and testbench
====================================

Name: zxuno_port_bridge

Overview:
Upstream neighbour of the register-mapped add-on interfaces such as the VERIPAC9 bridge. It watches the Z80 I/O bus and decodes the two ZX-UNO register ports: the address port (FC3B) and the data port (FD3B). It produces the registered zxuno_addr, a zxuno_regrd level and a single-cycle zxuno_regwr strobe, plus the latched write data consumed by every add-on register block. Z80 control strobes are treated as asynchronous to clk and are synchronised before use.

Parameters:
ADDR_PORT, 16'hFC3B, full 16-bit I/O address of the register-address port
DATA_PORT, 16'hFD3B, full 16-bit I/O address of the register-data port
SYNC_STAGES, 2, flip-flop stages on iorq_n/rd_n/wr_n/m1_n (legal 2..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_a  in  16  Z80 address bus
cpu_d  in  8  Z80 data bus (CPU write data)
iorq_n  in  1  Z80 IORQ, active low, async
rd_n  in  1  Z80 RD, active low, async
wr_n  in  1  Z80 WR, active low, async
m1_n  in  1  Z80 M1, active low; low together with iorq_n marks an interrupt acknowledge, which is ignored
zxuno_addr  out  8  currently selected register number
zxuno_regrd  out  1  level, high for the duration of a CPU read of DATA_PORT
zxuno_regwr  out  1  one-clk pulse per CPU write to DATA_PORT
zxuno_din  out  8  data latched from the CPU write, valid from the regwr cycle until the next write
dout  out  8  read data for an ADDR_PORT read (zxuno_addr); 8'h00 otherwise
oe_n  out  1  low while the CPU reads ADDR_PORT

Behaviour:
- Reset (async, rst_n=0): zxuno_addr=8'h00, zxuno_din=8'h00, zxuno_regrd=0, zxuno_regwr=0, oe_n=1, dout=8'h00, state=IDLE. All synchroniser flops preset to 1 (inactive).
- Synchronised signals s_iorq, s_rd, s_wr, s_m1 are active-high internal copies taken after SYNC_STAGES flops.
- cpu_a and cpu_d are sampled directly in the cycle in which the FSM leaves IDLE. Z80 timing holds them stable while IORQ is low.
- Qualified cycle: s_iorq=1, s_m1=0, and exactly one of s_rd/s_wr =1.
- FSM states:
  - IDLE. On a qualified write:
    - cpu_a==ADDR_PORT: zxuno_addr<=cpu_d; -> WAIT_END.
    - cpu_a==DATA_PORT: zxuno_din<=cpu_d, zxuno_regwr<=1 for exactly one cycle; -> WAIT_END.
  - IDLE. On a qualified read:
    - cpu_a==DATA_PORT: -> READ_DATA.
    - cpu_a==ADDR_PORT: -> READ_ADDR.
  - IDLE. Any other port, or s_rd and s_wr both set: -> WAIT_END with no outputs touched.
  - READ_DATA: zxuno_regrd=1 (registered). Leave to IDLE when s_iorq=0 or s_rd=0; regrd drops in the same cycle as the exit.
  - READ_ADDR: oe_n=0, dout=zxuno_addr. Exit under the same rule as READ_DATA.
  - WAIT_END: no strobes asserted. -> IDLE when s_iorq=0. This guarantees at most one action per I/O cycle.
- Latency: SYNC_STAGES clks from the IORQ/WR falling edge at the pins to the first state change. zxuno_regwr is high in clk cycle SYNC_STAGES+1. zxuno_addr updates in that same cycle.
- Timing requirement: clk must be at least 4x the Z80 clock so the synchronised strobe is seen inside the T-states.
- Writes to ADDR_PORT never pulse zxuno_regwr. Reads of ADDR_PORT never assert zxuno_regrd.
- zxuno_addr wraps freely: any 8-bit value is accepted, including FF.
- Interrupt acknowledge (m1_n low with iorq_n low) produces no strobes, even if cpu_a matches a port.
- rst_n asserted mid-cycle: the FSM returns to IDLE immediately and all strobes are deasserted. After release, an I/O cycle still in progress is only acted on if it is still present when the IDLE checks run. Tests must avoid releasing rst_n during IORQ.
- Outputs are all registered; no combinational path from the pins to the outputs.

Test Plan:
- Reset: hold rst_n=0 -> zxuno_addr=00, regrd=0, regwr=0, oe_n=1, dout=00. Release, idle bus 20 clk -> no strobes.
- OUT (FC3B),CA then OUT (FD3B),03 -> zxuno_addr=CA, no regwr on the first write. On the second write, exactly one regwr pulse, SYNC_STAGES+1 clk after the WR falling edge, with zxuno_din=03.
- IN (FD3B) with IORQ/RD low for 12 clk -> regrd high continuously from cycle SYNC_STAGES+1 until IORQ is released (sync delay included). Single rising edge; zxuno_addr unchanged.
- IN (FC3B) after OUT (FC3B),FB -> oe_n=0 and dout=FB during the read, oe_n=1 afterwards.
- Non-matching port FE3B write, and interrupt acknowledge (m1_n=0, iorq_n=0, cpu_a=FD3B) -> no regwr/regrd, zxuno_addr unchanged.
- Assert rst_n=0 in the middle of a DATA_PORT read -> regrd=0 and zxuno_addr=00 immediately (async). After release with the bus idle, no spurious strobe.

Source files
------------

// File: rtl/zxuno_port_bridge.sv
// ZX-UNO register port bridge.
// Decodes the Z80 I/O cycles aimed at the ZX-UNO address port (FC3B) and
// data port (FD3B). It holds the selected register number and hands the
// add-on register blocks a read level, a one-cycle write strobe and the
// latched write data.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cpu_a[15:0], cpu_d[7:0]    Z80 address / write-data bus
//   iorq_n, rd_n, wr_n, m1_n   Z80 control strobes (async to clk)
//   zxuno_addr[7:0]            selected register number
//   zxuno_regrd                level while the CPU reads DATA_PORT
//   zxuno_regwr                one-clk pulse per CPU write to DATA_PORT
//   zxuno_din[7:0]             data from the last DATA_PORT write
//   dout[7:0], oe_n            read-back of zxuno_addr on ADDR_PORT reads
module zxuno_port_bridge #(
  parameter logic [15:0] ADDR_PORT   = 16'hFC3B,
  parameter logic [15:0] DATA_PORT   = 16'hFD3B,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_din,
  output logic [7:0]  dout,
  output logic        oe_n
);

  typedef enum logic [1:0] {IDLE, WAIT_END, READ_DATA, READ_ADDR} state_t;

  // Synchronisers preset to 1 so reset looks like an idle bus.
  logic [SYNC_STAGES-1:0] iorq_sq, rd_sq, wr_sq, m1_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sq <= '1;
      rd_sq   <= '1;
      wr_sq   <= '1;
      m1_sq   <= '1;
    end else begin
      iorq_sq <= {iorq_sq[SYNC_STAGES-2:0], iorq_n};
      rd_sq   <= {rd_sq[SYNC_STAGES-2:0], rd_n};
      wr_sq   <= {wr_sq[SYNC_STAGES-2:0], wr_n};
      m1_sq   <= {m1_sq[SYNC_STAGES-2:0], m1_n};
    end
  end

  logic s_iorq, s_rd, s_wr, s_m1, qual;
  assign s_iorq = ~iorq_sq[SYNC_STAGES-1];
  assign s_rd   = ~rd_sq[SYNC_STAGES-1];
  assign s_wr   = ~wr_sq[SYNC_STAGES-1];
  assign s_m1   = ~m1_sq[SYNC_STAGES-1];
  // Interrupt acknowledge (M1 with IORQ) and RD+WR together never qualify.
  assign qual   = s_iorq & ~s_m1 & (s_rd ^ s_wr);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d, din_q, din_d, dout_q, dout_d;
  logic        regwr_q, regwr_d, regrd_q, regrd_d, oe_n_q, oe_n_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    regwr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (qual && s_wr) begin
          if (cpu_a == ADDR_PORT) begin
            addr_d = cpu_d;
          end else if (cpu_a == DATA_PORT) begin
            din_d   = cpu_d;
            regwr_d = 1'b1;
          end
          state_d = WAIT_END;
        end else if (qual && s_rd) begin
          if (cpu_a == DATA_PORT)      state_d = READ_DATA;
          else if (cpu_a == ADDR_PORT) state_d = READ_ADDR;
          else                         state_d = WAIT_END;
        end else if (s_iorq && (s_rd || s_wr || s_m1)) begin
          // Unqualified cycle: park until IORQ ends so it is never acted on.
          state_d = WAIT_END;
        end
      end
      READ_DATA, READ_ADDR: if (!s_iorq || !s_rd) state_d = IDLE;
      WAIT_END:             if (!s_iorq)          state_d = IDLE;
      default:              state_d = IDLE;
    endcase
    // Read outputs follow the next state so they drop on the exit edge.
    regrd_d = (state_d == READ_DATA);
    oe_n_d  = (state_d != READ_ADDR);
    dout_d  = (state_d == READ_ADDR) ? addr_d : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      din_q   <= 8'h00;
      regwr_q <= 1'b0;
      regrd_q <= 1'b0;
      oe_n_q  <= 1'b1;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      regwr_q <= regwr_d;
      regrd_q <= regrd_d;
      oe_n_q  <= oe_n_d;
      dout_q  <= dout_d;
    end
  end

  assign zxuno_addr  = addr_q;
  assign zxuno_din   = din_q;
  assign zxuno_regwr = regwr_q;
  assign zxuno_regrd = regrd_q;
  assign oe_n        = oe_n_q;
  assign dout        = dout_q;

endmodule

// File: tb/tb_zxuno_port_bridge.sv
// Self-checking bench for zxuno_port_bridge: directed Z80 I/O cycles, a
// transaction-level model checked every cycle, plus literal expectations.
module tb_zxuno_port_bridge;
  localparam int          S  = 2;
  localparam logic [15:0] AP = 16'hFC3B;
  localparam logic [15:0] DP = 16'hFD3B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [7:0]  zxuno_addr, zxuno_din, dout;
  logic        zxuno_regrd, zxuno_regwr, oe_n;

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  zxuno_port_bridge #(.ADDR_PORT(AP), .DATA_PORT(DP), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .zxuno_din(zxuno_din),
    .dout(dout), .oe_n(oe_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the bridge sees the bus as it was S clock edges ago; each IORQ
  // period is acted on once, at its first visible edge.
  typedef struct packed {
    logic iorq, rd, wr, m1;
    logic [15:0] a;
    logic [7:0]  d;
  } pin_t;

  pin_t hist [0:S];
  pin_t v, p;
  logic start, qual;
  assign v     = hist[S-1];
  assign p     = hist[S];
  assign start = v.iorq && !p.iorq;
  assign qual  = v.iorq && !v.m1 && (v.rd ^ v.wr);

  logic [7:0] m_addr, m_din, m_dout;
  logic       m_regwr, m_regrd, m_oe_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= S; i++) hist[i] <= '0;
      m_addr <= 8'h00; m_din <= 8'h00; m_dout <= 8'h00;
      m_regwr <= 1'b0; m_regrd <= 1'b0; m_oe_n <= 1'b1;
    end else begin
      hist[0] <= '{iorq: !iorq_n, rd: !rd_n, wr: !wr_n, m1: !m1_n, a: cpu_a, d: cpu_d};
      for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
      m_regwr <= start && qual && v.wr && (v.a == DP);
      if (start && qual && v.wr && v.a == AP) m_addr <= v.d;
      if (start && qual && v.wr && v.a == DP) m_din  <= v.d;
      m_regrd <= qual && v.rd && (v.a == DP);
      m_oe_n  <= !(qual && v.rd && (v.a == AP));
      m_dout  <= (qual && v.rd && (v.a == AP)) ? m_addr : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_regwr", {15'd0, zxuno_regwr}, {15'd0, m_regwr});
      chk("m_regrd", {15'd0, zxuno_regrd}, {15'd0, m_regrd});
      chk("m_oe_n",  {15'd0, oe_n},        {15'd0, m_oe_n});
      chk("m_addr",  {8'd0, zxuno_addr},   {8'd0, m_addr});
      chk("m_din",   {8'd0, zxuno_din},    {8'd0, m_din});
      chk("m_dout",  {8'd0, dout},         {8'd0, m_dout});
    end
  end

  // kind: 0 write, 1 read, 2 interrupt acknowledge
  task automatic io(input int kind, input logic [15:0] a, input logic [7:0] d,
                    input int len, output int wr_k, output int pulses,
                    output int rd_k, output int rd_cnt,
                    output logic oe_end, output logic [7:0] dout_end);
    @(negedge clk);
    cpu_a = a; cpu_d = d; iorq_n = 1'b0;
    if (kind == 0) wr_n = 1'b0;
    if (kind == 1) rd_n = 1'b0;
    if (kind == 2) m1_n = 1'b0;
    wr_k = 0; pulses = 0; rd_k = 0; rd_cnt = 0; oe_end = 1'b1; dout_end = 8'h00;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (zxuno_regwr) begin pulses++; if (wr_k == 0) wr_k = k; end
      if (zxuno_regrd) begin rd_cnt++; if (rd_k == 0) rd_k = k; end
      if (k == len) begin oe_end = oe_n; dout_end = dout; end
    end
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (zxuno_regwr) pulses++;
    end
  endtask

  int wk, np, rk, rc;
  logic oe_e;
  logic [7:0] do_e;

  initial begin
    #2 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr",  {8'd0, zxuno_addr}, 16'h0000);
    chk("rst_regrd", {15'd0, zxuno_regrd}, 16'h0000);
    chk("rst_regwr", {15'd0, zxuno_regwr}, 16'h0000);
    chk("rst_oe_n",  {15'd0, oe_n}, 16'h0001);
    chk("rst_dout",  {8'd0, dout}, 16'h0000);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    io(0, AP, 8'hCA, 8, wk, np, rk, rc, oe_e, do_e);
    chk("addr_wr_no_regwr", np[15:0], 16'd0);
    chk("addr_wr_value", {8'd0, zxuno_addr}, 16'h00CA);

    io(0, DP, 8'h03, 8, wk, np, rk, rc, oe_e, do_e);
    chk("data_wr_pulses", np[15:0], 16'd1);
    chk("data_wr_latency", wk[15:0], 16'(S + 1));
    chk("data_wr_din", {8'd0, zxuno_din}, 16'h0003);
    chk("data_wr_addr_kept", {8'd0, zxuno_addr}, 16'h00CA);

    io(1, DP, 8'h00, 12, wk, np, rk, rc, oe_e, do_e);
    chk("data_rd_first", rk[15:0], 16'(S + 1));
    chk("data_rd_len", rc[15:0], 16'(12 - S));
    chk("data_rd_no_regwr", np[15:0], 16'd0);
    chk("data_rd_addr_kept", {8'd0, zxuno_addr}, 16'h00CA);

    io(0, AP, 8'hFB, 8, wk, np, rk, rc, oe_e, do_e);
    io(1, AP, 8'h00, 8, wk, np, rk, rc, oe_e, do_e);
    chk("addr_rd_oe", {15'd0, oe_e}, 16'h0000);
    chk("addr_rd_dout", {8'd0, do_e}, 16'h00FB);
    chk("addr_rd_no_regrd", rk[15:0], 16'd0);
    chk("addr_rd_oe_after", {15'd0, oe_n}, 16'h0001);

    io(0, 16'hFE3B, 8'h55, 8, wk, np, rk, rc, oe_e, do_e);
    chk("other_wr_pulses", np[15:0], 16'd0);
    chk("other_wr_addr", {8'd0, zxuno_addr}, 16'h00FB);
    io(1, 16'hFE3B, 8'h00, 8, wk, np, rk, rc, oe_e, do_e);
    chk("other_rd_regrd", rk[15:0], 16'd0);
    io(2, DP, 8'h77, 8, wk, np, rk, rc, oe_e, do_e);
    chk("intack_pulses", np[15:0], 16'd0);
    chk("intack_regrd", rk[15:0], 16'd0);
    chk("intack_din", {8'd0, zxuno_din}, 16'h0003);

    io(0, AP, 8'hFF, 8, wk, np, rk, rc, oe_e, do_e);
    chk("addr_ff", {8'd0, zxuno_addr}, 16'h00FF);

    // Reset in the middle of a DATA_PORT read.
    @(negedge clk);
    cpu_a = DP; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrd_regrd_before", {15'd0, zxuno_regrd}, 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    chk("midrd_rst_regrd", {15'd0, zxuno_regrd}, 16'h0000);
    chk("midrd_rst_addr", {8'd0, zxuno_addr}, 16'h0000);
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    np = 0; rc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (zxuno_regwr) np++;
      if (zxuno_regrd) rc++;
    end
    chk("post_rst_regwr", np[15:0], 16'd0);
    chk("post_rst_regrd", rc[15:0], 16'd0);
    chk("post_rst_addr", {8'd0, zxuno_addr}, 16'h0000);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
